// File: rtl/mcu_pkg.sv
// mcu_pkg: state codes, opcodes, instruction classes and ALUOp encodings for the multicycle controller.
package mcu_pkg;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;
  typedef enum logic [2:0] {
    C_LOAD   = 3'd0,
    C_STORE  = 3'd1,
    C_RTYPE  = 3'd2,
    C_BRANCH = 3'd3,
    C_ITYPE  = 3'd4
  } cls_t;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
endpackage

// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: controller <-> datapath signals; master is the controller, slave the datapath.
interface multicycle_control_unit_if #(
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 16
);
  logic [6:0]         opcode;
  logic               zero;
  logic               mem_ready;
  logic               pc_write;
  logic               ir_write;
  logic               mem_read;
  logic               mem_write;
  logic               mem_to_reg;
  logic               alu_src;
  logic               reg_write;
  logic               branch_taken;
  logic [ALUOP_W-1:0] alu_op;
  logic               illegal;
  logic [2:0]         state;
  logic [CNT_W-1:0]   retired;
  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, ir_write, mem_read, mem_write, mem_to_reg, alu_src, reg_write,
    output branch_taken, alu_op, illegal, state, retired
  );
  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, ir_write, mem_read, mem_write, mem_to_reg, alu_src, reg_write,
    input  branch_taken, alu_op, illegal, state, retired
  );
endinterface

// File: rtl/mcu_opcode_decoder.sv
// mcu_opcode_decoder: combinational opcode -> instruction class, flagging unsupported opcodes.
module mcu_opcode_decoder
  import mcu_pkg::*;
(
  input  logic [6:0] i_opcode,
  output cls_t       o_cls,
  output logic       o_illegal
);
  always_comb begin
    o_cls = i_opcode == OP_STORE  ? C_STORE  :
            i_opcode == OP_RTYPE  ? C_RTYPE  :
            i_opcode == OP_BRANCH ? C_BRANCH :
            i_opcode == OP_ITYPE  ? C_ITYPE  : C_LOAD;
    o_illegal = !(i_opcode inside {OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, OP_ITYPE});
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB controller with illegal-opcode trap and retire counter.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int                 ALUOP_W     = 2,
  parameter int                 CNT_W       = 16,
  parameter logic [ALUOP_W-1:0] ITYPE_ALUOP = ALUOP_W'(2'b11)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  multicycle_control_unit_if.master     bus
);
  state_t           r_state, w_next;
  cls_t             r_cls, w_cls;
  logic             w_ill, w_retire;
  logic [CNT_W-1:0] r_retired;
  mcu_opcode_decoder u_dec (.i_opcode(bus.opcode), .o_cls(w_cls), .o_illegal(w_ill));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_FETCH;
      r_cls     <= C_LOAD;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_cls <= w_cls;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end
  assign bus.state   = r_state;
  assign bus.retired = r_retired;
  // Strobes are gated by reset_n directly so they drop the moment reset asserts.
  always_comb begin
    w_next           = S_FETCH;
    w_retire         = 1'b0;
    bus.pc_write     = 1'b0;
    bus.ir_write     = 1'b0;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.mem_to_reg   = 1'b0;
    bus.alu_src      = 1'b0;
    bus.reg_write    = 1'b0;
    bus.branch_taken = 1'b0;
    bus.alu_op       = '0;
    bus.illegal      = 1'b0;
    if (reset_n) begin
      case (r_state)
        S_FETCH: begin
          bus.mem_read = 1'b1;
          bus.pc_write = bus.mem_ready;
          bus.ir_write = bus.mem_ready;
          w_next       = bus.mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: w_next = w_ill ? S_TRAP : S_EXEC;
        S_EXEC: begin
          bus.alu_src      = r_cls inside {C_LOAD, C_STORE, C_ITYPE};
          bus.alu_op       = r_cls == C_BRANCH ? ALUOP_W'(ALU_BR) :
                             r_cls == C_RTYPE  ? ALUOP_W'(ALU_R)  :
                             r_cls == C_ITYPE  ? ITYPE_ALUOP      : ALUOP_W'(ALU_ADD);
          bus.pc_write     = r_cls == C_BRANCH && bus.zero;
          bus.branch_taken = r_cls == C_BRANCH && bus.zero;
          w_retire         = r_cls == C_BRANCH;
          w_next           = r_cls == C_BRANCH ? S_FETCH :
                             r_cls inside {C_LOAD, C_STORE} ? S_MEM : S_WB;
        end
        S_MEM: begin
          bus.mem_read  = r_cls == C_LOAD;
          bus.mem_write = r_cls == C_STORE;
          w_retire      = r_cls == C_STORE && bus.mem_ready;
          w_next        = !bus.mem_ready ? S_MEM : r_cls == C_LOAD ? S_WB : S_FETCH;
        end
        S_WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = r_cls == C_LOAD;
          w_retire       = 1'b1;
        end
        S_TRAP: begin
          bus.illegal = 1'b1;
          w_next      = S_TRAP;
        end
        default: w_next = S_FETCH;
      endcase
    end
  end
endmodule
